// File: rtl/ifid_hazard_ctrl_pkg.sv
// Shared pipeline types for the IF/ID hazard controller: FSM states, register-zero
// constant, field widths and the canned control words driven onto the stage enables.
package ifid_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned PERF_CNT_W = 16;
    localparam int unsigned CTRL_W     = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        StRun,
        StLuStall,
        StFreeze
    } hz_state_e;

    typedef struct packed {
        logic pc_ld;
        logic ifid_ld;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_ld;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET  = '{pc_ld: 1'b0, ifid_ld: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, pipe_ld: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{pc_ld: 1'b0, ifid_ld: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pipe_ld: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{pc_ld: 1'b0, ifid_ld: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, pipe_ld: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_ld: 1'b1, ifid_ld: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b0, pipe_ld: 1'b1};
    localparam ctrl_t CTRL_RUN    = '{pc_ld: 1'b1, ifid_ld: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pipe_ld: 1'b1};

endpackage

// File: rtl/ifid_hazard_ctrl_hazard_detect.sv
// Pure combinational load-use compare (hazard_detect) between the EX load and the
// ID instruction's sources; shared with the forwarding unit.
module ifid_hazard_ctrl_hazard_detect
    import ifid_hazard_ctrl_pkg::*;
(
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  lu_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rd_i == id_rs_i);
    assign rt_match = id_uses_rt_i & (ex_rd_i == id_rt_i);
    // A load into r0 never produces a value, so it can never hazard.
    assign lu_o     = ex_mem_read_i & (ex_rd_i != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID + PC sequencing: load-use stalls, branch squash, memory freeze, perf counters.
// Perf counters are built only when IFID_HAZARD_PERF_EN is defined; otherwise tied to 0.
module ifid_hazard_ctrl
    import ifid_hazard_ctrl_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1  // legal range 1..4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_branch_taken_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  mem_wait_i,
    output logic                  pc_ld_o,
    output logic                  ifid_ld_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  pipe_ld_o,
    output logic [PERF_CNT_W-1:0] stall_count_o,
    output logic [PERF_CNT_W-1:0] flush_count_o
);

    // The first stall cycle is spent in RUN, so LU_STALL covers the remaining N-1.
    localparam logic [1:0] LU_REM_INIT =
        (LU_STALL_CYCLES > 1) ? 2'(LU_STALL_CYCLES - 2) : 2'd0;

    hz_state_e state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       ret_lu_q, ret_lu_d;
    logic       lu;
    logic       in_lu_stall;
    ctrl_t      ctrl;

    ifid_hazard_ctrl_hazard_detect u_hazard_detect (
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .lu_o          (lu)
    );

    // FREEZE behaves as whichever state it will return to once memory is ready.
    assign in_lu_stall = (state_q == StLuStall) | ((state_q == StFreeze) & ret_lu_q);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        ret_lu_d = ret_lu_q;
        ctrl     = CTRL_RUN;
        if (reset_i) begin
            ctrl = CTRL_RESET;
        end else if (mem_wait_i) begin
            ctrl     = CTRL_FREEZE;
            state_d  = StFreeze;
            ret_lu_d = in_lu_stall;
        end else if (in_lu_stall) begin
            ctrl = CTRL_STALL;
            if (rem_q == 2'd0) begin
                state_d = StRun;
            end else begin
                state_d = StLuStall;
                rem_d   = rem_q - 2'd1;
            end
        end else if (lu) begin
            ctrl = CTRL_STALL;
            if (LU_STALL_CYCLES > 1) begin
                state_d = StLuStall;
                rem_d   = LU_REM_INIT;
            end else begin
                state_d = StRun;
            end
        end else if (id_branch_taken_i) begin
            ctrl    = CTRL_FLUSH;
            state_d = StRun;
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StRun;
            rem_q    <= 2'd0;
            ret_lu_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            ret_lu_q <= ret_lu_d;
        end
    end

    assign pc_ld_o       = ctrl.pc_ld;
    assign ifid_ld_o     = ctrl.ifid_ld;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_bubble_o = ctrl.idex_bubble;
    assign pipe_ld_o     = ctrl.pipe_ld;

`ifdef IFID_HAZARD_PERF_EN
    localparam logic [PERF_CNT_W-1:0] PERF_ONE = PERF_CNT_W'(1);

    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_ld && !mem_wait_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + PERF_ONE;
        end
        if (ctrl.ifid_flush && !reset_i && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;
`else
    assign stall_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Scoreboard bench: two controllers (1 and 3 stall cycles) share stimulus; a
// remaining-stall-cycles reference model queues expectations, a monitor checks them.
module tb_ifid_hazard_ctrl;

    localparam int unsigned LU_A = 1;
    localparam int unsigned LU_B = 3;

    typedef struct packed {
        logic [4:0]  ctrl;  // pc_ld, ifid_ld, ifid_flush, idex_bubble, pipe_ld
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, id_uses_rt, id_branch_taken, ex_mem_read, mem_wait;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic [1:0] pc_ld, ifid_ld, ifid_flush, idex_bubble, pipe_ld;
    logic [15:0] stall_count [2];
    logic [15:0] flush_count [2];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   left [2];
    int   sc [2];
    int   fc [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    ifid_hazard_ctrl #(.LU_STALL_CYCLES(LU_A)) u_dut_a (
        .clk_i             (clk),
        .reset_i           (reset),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .id_branch_taken_i (id_branch_taken),
        .ex_mem_read_i     (ex_mem_read),
        .ex_rd_i           (ex_rd),
        .mem_wait_i        (mem_wait),
        .pc_ld_o           (pc_ld[0]),
        .ifid_ld_o         (ifid_ld[0]),
        .ifid_flush_o      (ifid_flush[0]),
        .idex_bubble_o     (idex_bubble[0]),
        .pipe_ld_o         (pipe_ld[0]),
        .stall_count_o     (stall_count[0]),
        .flush_count_o     (flush_count[0])
    );

    ifid_hazard_ctrl #(.LU_STALL_CYCLES(LU_B)) u_dut_b (
        .clk_i             (clk),
        .reset_i           (reset),
        .id_rs_i           (id_rs),
        .id_rt_i           (id_rt),
        .id_uses_rt_i      (id_uses_rt),
        .id_branch_taken_i (id_branch_taken),
        .ex_mem_read_i     (ex_mem_read),
        .ex_rd_i           (ex_rd),
        .mem_wait_i        (mem_wait),
        .pc_ld_o           (pc_ld[1]),
        .ifid_ld_o         (ifid_ld[1]),
        .ifid_flush_o      (ifid_flush[1]),
        .idex_bubble_o     (idex_bubble[1]),
        .pipe_ld_o         (pipe_ld[1]),
        .stall_count_o     (stall_count[1]),
        .flush_count_o     (flush_count[1])
    );

    // Reference model: a count of stall cycles still owed; freezes simply pause time.
    task automatic step(input logic r, input logic mw, input logic mr, input logic br,
                        input logic ur, input logic [4:0] exrd, input logic [4:0] rs,
                        input logic [4:0] rt);
        exp_t e;
        logic lu;
        int   n;
        @(posedge clk);
        #1;
        reset = r; mem_wait = mw; ex_mem_read = mr; id_branch_taken = br;
        id_uses_rt = ur; ex_rd = exrd; id_rs = rs; id_rt = rt;
        lu = mr && (exrd != 5'd0) && ((exrd == rs) || (ur && (exrd == rt)));
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? LU_A : LU_B;
            if (r)                      e.ctrl = 5'b01111;
            else if (mw)                e.ctrl = 5'b00000;
            else if (left[d] > 0 || lu) e.ctrl = 5'b00011;
            else if (br)                e.ctrl = 5'b11101;
            else                        e.ctrl = 5'b11001;
`ifdef IFID_HAZARD_PERF_EN
            e.sc = sc[d][15:0];
            e.fc = fc[d][15:0];
`else
            e.sc = 16'd0;
            e.fc = 16'd0;
`endif
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            if (r) begin
                left[d] = 0; sc[d] = 0; fc[d] = 0;
            end else begin
                if (!mw) begin
                    if (left[d] > 0) left[d] = left[d] - 1;
                    else if (lu)     left[d] = n - 1;
                    if (!e.ctrl[4] && sc[d] < 65535) sc[d] = sc[d] + 1;
                end
                if (e.ctrl[2] && fc[d] < 65535) fc[d] = fc[d] + 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [4:0] got;
        for (int d = 0; d < 2; d++) begin
            if ((d == 0 ? q0.size() : q1.size()) > 0) begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                got = {pc_ld[d], ifid_ld[d], ifid_flush[d], idex_bubble[d], pipe_ld[d]};
                checks++;
                if (got !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl dut%0d t=%0t: got %b expected %b", d, $time, got,
                             e.ctrl);
                end
                checks++;
                if (stall_count[d] !== e.sc || flush_count[d] !== e.fc) begin
                    errors++;
                    $display("FAIL counters dut%0d t=%0t: got stall %0d flush %0d expected %0d %0d",
                             d, $time, stall_count[d], flush_count[d], e.sc, e.fc);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            left[d] = 0; sc[d] = 0; fc[d] = 0;
        end
        reset = 1'b1; mem_wait = 1'b0; ex_mem_read = 1'b0; id_branch_taken = 1'b0;
        id_uses_rt = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        repeat (2) @(posedge clk);

        step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step(1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);        // reset beats everything
        idle(2);
        // Load-use on rs, load leaves EX afterwards.
        step(0, 0, 1, 0, 0, 5'd5, 5'd5, 5'd0);
        idle(4);
        // r0 never hazards; rt only when it is used.
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step(0, 0, 1, 0, 0, 5'd7, 5'd1, 5'd7);
        step(0, 0, 1, 0, 1, 5'd7, 5'd1, 5'd7);
        idle(3);
        // Taken branch squash.
        step(0, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2);
        idle(1);
        // Freeze in the middle of a multi-cycle stall.
        step(0, 0, 1, 0, 0, 5'd5, 5'd5, 5'd0);
        repeat (4) step(0, 1, 0, 0, 0, 5'd0, 5'd5, 5'd0);
        idle(4);
        // Reset while stalled.
        step(0, 0, 1, 0, 0, 5'd9, 5'd9, 5'd0);
        step(1, 0, 0, 0, 0, 5'd0, 5'd9, 5'd0);
        idle(2);
        // Branch held by stall, and freeze colliding with hazard/branch.
        step(0, 0, 1, 1, 0, 5'd4, 5'd4, 5'd0);
        step(0, 0, 0, 1, 0, 5'd0, 5'd4, 5'd0);
        step(0, 0, 0, 1, 0, 5'd0, 5'd4, 5'd0);
        step(0, 0, 0, 1, 0, 5'd0, 5'd4, 5'd0);
        step(0, 1, 1, 1, 0, 5'd6, 5'd6, 5'd0);
        step(0, 0, 1, 1, 0, 5'd6, 5'd6, 5'd0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        idle(2);

        @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d queued expected 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifid_hazard_ctrl.md
# ifid_hazard_ctrl

Pipeline hazard and stall controller that sequences the IF/ID pipeline register and the PC. It decodes load-use hazards between the instruction held in IF/ID and the load in EX, squashes the fetched instruction on a taken branch resolved in ID, and freezes the whole pipeline while data memory is busy. A small FSM holds multi-cycle load-use stalls across memory freezes. Instantiated once in the pipeline top, beside the IF/ID stage.

## Interface

- LU_STALL_CYCLES, 1, stall cycles inserted per load-use hazard; legal range 1..4.
- clk  in  1  pipeline clock. Single clock domain.
- reset  in  1  reset; synchronous, active-high.
- id_rs  in  5  rs field of the IF/ID instruction (bits 25:21).
- id_rt  in  5  rt field of the IF/ID instruction (bits 20:16).
- id_uses_rt  in  1  decoder flag: the ID instruction reads rt as a source.
- id_branch_taken  in  1  branch or jump in ID resolved as taken.
- ex_mem_read  in  1  the instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- mem_wait  in  1  data memory not ready; hold every stage.
- pc_ld  out  1  PC load enable.
- ifid_ld  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID synchronous clear (loads a NOP).
- idex_bubble  out  1  force NOP control word into ID/EX.
- pipe_ld  out  1  load enable for ID/EX, EX/MEM and MEM/WB.
- stall_count  out  16  stall cycles seen (perf).
- flush_count  out  16  branch squashes seen (perf).

## Operation

- Hazard term lu = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))). Register 0 never hazards.
- FSM states: RUN, LU_STALL, FREEZE. It holds a 2-bit remaining-stall counter rem and a 1-bit saved return state.
- Output priority: reset > mem_wait > stall (LU_STALL, or lu in RUN) > branch > normal.
- mem_wait high, any state: pc_ld=0, ifid_ld=0, pipe_ld=0, ifid_flush=0, idex_bubble=0.
  - Next state FREEZE. Save the return state (RUN or LU_STALL). rem holds.
- FREEZE with mem_wait low: return to the saved state. Outputs in that cycle follow the saved state's rules.
- RUN with lu: pc_ld=0, ifid_ld=0, idex_bubble=1, pipe_ld=1.
  - If LU_STALL_CYCLES>1: next state LU_STALL, rem=LU_STALL_CYCLES-2. Otherwise stay in RUN.
- LU_STALL: same outputs as a stall. The hazard is not re-evaluated.
  - Leave for RUN when rem==0; otherwise decrement rem.
- RUN, no lu, id_branch_taken: pc_ld=1, ifid_ld=1, ifid_flush=1, pipe_ld=1.
  - The fetched instruction is squashed and the target is loaded.
- RUN, idle: pc_ld=1, ifid_ld=1, pipe_ld=1, ifid_flush=0, idex_bubble=0.
- A branch that is held back by a stall is acted on in the first non-stalled RUN cycle, since IF/ID still holds it.

## Timing

- All outputs are combinational from the current state and inputs, with zero latency. Stalls take effect in the same cycle the hazard is visible.
- State, rem and counters update on the rising edge of clk.
- While reset is high: pc_ld=0, ifid_ld=1, ifid_flush=1, idex_bubble=1, pipe_ld=1.
  - At the edge, state=RUN, rem=0, stall_count=0, flush_count=0.
- Reset mid-stall or mid-freeze abandons the sequence. The first cycle after reset is RUN.
- Total stall per load-use hazard is exactly LU_STALL_CYCLES cycles, not counting cycles spent in FREEZE.
- mem_wait in the same cycle as lu or id_branch_taken: freeze wins. The hazard or branch is re-evaluated after the freeze.

## Configuration

- IFID_HAZARD_PERF_EN defined:
  - stall_count increments every cycle in which pc_ld=0 and mem_wait=0.
  - flush_count increments every cycle with ifid_flush=1 and reset low.
  - Both counters saturate at 16'hFFFF.
- IFID_HAZARD_PERF_EN undefined: the counter logic is removed and both ports are tied to 0.

## Structure

- The shared pipeline package holds:
  - the state enum (RUN, LU_STALL, FREEZE);
  - the REG_ZERO constant;
  - the control-word field widths.
- A single sub-module, hazard_detect, holds the pure combinational lu compare. It is reused later by the forwarding unit.
- The FSM and counters live in the top module.

## Test plan

- ex_mem_read=1, ex_rd=5, id_rs=5, LU_STALL_CYCLES=1 -> one cycle with pc_ld=0, ifid_ld=0, idex_bubble=1; the next cycle is normal.
- Same stimulus with LU_STALL_CYCLES=3, and ex_mem_read dropping after cycle 1 -> exactly 3 stall cycles, then RUN.
- ex_rd=0, id_rs=0, ex_mem_read=1 -> no stall. ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall.
- id_branch_taken=1 for one cycle -> ifid_flush=1 and pc_ld=1 in that cycle. With the perf macro defined, flush_count goes 0->1.
- LU_STALL_CYCLES=3, mem_wait raised for 4 cycles during the second stall cycle:
  - all load enables are 0 for 4 cycles;
  - then 2 more stall cycles follow;
  - stall_count ends at 3.
- Reset asserted during LU_STALL -> the reset output values hold; the first post-reset cycle is normal RUN with counters at 0.
